// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : MIPS F-stage front end. Program counter, next-PC selection
//               with architectural delay slots, F/D register and fetch count.
//               FETCH_ADDR_CHECK_EN enables the fetch address fault (F_exc).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  D_npc_sel,
    input  logic        D_br_taken,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] F_instr,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic [31:0] fetch_cnt,
    output logic        F_exc
);

    localparam logic [1:0] c_sel_seq = 2'b00;
    localparam logic [1:0] c_sel_br  = 2'b01;
    localparam logic [1:0] c_sel_j   = 2'b10;
    localparam logic [1:0] c_sel_jr  = 2'b11;

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic c_check_en = 1'b1;
`else
    localparam logic c_check_en = 1'b0;
`endif

    // 33-bit bounds so an image ending at the top of the address space cannot overflow
    localparam logic [32:0] c_im_lo = {1'b0, PC_RESET};
    localparam logic [32:0] c_im_hi = c_im_lo + (33'(IM_WORDS) << 2);

    logic [31:0] r_f_pc;
    logic [31:0] r_d_pc;
    logic [31:0] r_d_instr;
    logic        r_d_valid;
    logic [31:0] r_fetch_cnt;

    logic        w_redirect;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_imm_ext;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_npc;
    logic        w_addr_fault;
    logic        w_f_exc;

    assign w_redirect = r_d_valid &
                        ((D_npc_sel == c_sel_j) ||
                         (D_npc_sel == c_sel_jr) ||
                         ((D_npc_sel == c_sel_br) && D_br_taken));

    assign w_pc_plus4  = r_f_pc + 32'd4;
    assign w_imm_ext   = {{14{r_d_instr[15]}}, r_d_instr[15:0], 2'b00};
    assign w_br_target = r_d_pc + 32'd4 + w_imm_ext;
    assign w_j_target  = {r_d_pc[31:28], r_d_instr[25:0], 2'b00};

    always_comb begin
        w_npc = w_pc_plus4;
        if (w_redirect) begin
            case (D_npc_sel)
                c_sel_br:  w_npc = w_br_target;
                c_sel_j:   w_npc = w_j_target;
                c_sel_jr:  w_npc = D_rs_data;
                c_sel_seq: w_npc = w_pc_plus4;
                default:   w_npc = w_pc_plus4;
            endcase
        end
    end

    assign w_addr_fault = (r_f_pc[1:0] != 2'b00) ||
                          ({1'b0, r_f_pc} < c_im_lo) ||
                          ({1'b0, r_f_pc} >= c_im_hi);
    assign w_f_exc      = c_check_en & w_addr_fault;

    // A faulting fetch still advances the PC but enters D as an uncounted bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f_pc      <= PC_RESET;
            r_d_pc      <= PC_RESET;
            r_d_instr   <= 32'h0000_0000;
            r_d_valid   <= 1'b0;
            r_fetch_cnt <= 32'h0000_0000;
        end else if (!stall) begin
            r_f_pc <= w_npc;
            r_d_pc <= r_f_pc;
            if (w_f_exc) begin
                r_d_instr <= 32'h0000_0000;
                r_d_valid <= 1'b0;
            end else begin
                r_d_instr   <= F_instr;
                r_d_valid   <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign F_PC      = r_f_pc;
    assign D_PC      = r_d_pc;
    assign D_instr   = r_d_instr;
    assign D_valid   = r_d_valid;
    assign fetch_cnt = r_fetch_cnt;
    assign F_exc     = w_f_exc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with an expected-state queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic [31:0] f_pc;
        logic [31:0] d_pc;
        logic [31:0] d_instr;
        logic        d_valid;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  D_npc_sel;
    logic        D_br_taken;
    logic [31:0] D_rs_data;
    logic [31:0] F_instr;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic        D_valid;
    logic [31:0] fetch_cnt;
    logic        F_exc;

    logic [31:0] imem [0:127];
    exp_t        sb [$];
    int          n_chk;
    int          n_err;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .D_npc_sel  (D_npc_sel),
        .D_br_taken (D_br_taken),
        .D_rs_data  (D_rs_data),
        .F_instr    (F_instr),
        .F_PC       (F_PC),
        .D_PC       (D_PC),
        .D_instr    (D_instr),
        .D_valid    (D_valid),
        .fetch_cnt  (fetch_cnt),
        .F_exc      (F_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign F_instr = imem[F_PC[8:2]];

    // Minimal D-stage decoder: beq, j/jal, jr
    always_comb begin
        D_npc_sel = 2'b00;
        case (D_instr[31:26])
            6'b000100:        D_npc_sel = 2'b01;
            6'b000010,
            6'b000011:        D_npc_sel = 2'b10;
            6'b000000:        if (D_instr[5:0] == 6'b001000) D_npc_sel = 2'b11;
            default:          D_npc_sel = 2'b00;
        endcase
    end

    function automatic logic [31:0] mem_at(input logic [31:0] addr);
        return imem[addr[8:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 128; i++) imem[i] = 32'h2000_0000 | 32'(i);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_fpc"},   F_PC,             32'h0000_3000);
        chk({tag, "_dpc"},   D_PC,             32'h0000_3000);
        chk({tag, "_dinst"}, D_instr,          32'h0);
        chk({tag, "_dval"},  {31'b0, D_valid}, 32'h0);
        chk({tag, "_cnt"},   fetch_cnt,        32'h0);
        chk({tag, "_exc"},   {31'b0, F_exc},   32'h0);
    endtask

    task automatic do_reset();
        stall = 1'b0;
        reset = 1'b1;
        #1;
        reset_checks("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Push the expected post-edge state, clock once, pop and compare
    task automatic step(input string tag, input logic s, input logic [31:0] fpc,
                        input logic [31:0] dpc, input logic dv, input logic [31:0] cnt);
        exp_t e;
        e.f_pc    = fpc;
        e.d_pc    = dpc;
        e.d_instr = dv ? mem_at(dpc) : 32'h0;
        e.d_valid = dv;
        e.cnt     = cnt;
        sb.push_back(e);
        stall = s;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_fpc"},   F_PC,             e.f_pc);
        chk({tag, "_dpc"},   D_PC,             e.d_pc);
        chk({tag, "_dinst"}, D_instr,          e.d_instr);
        chk({tag, "_dval"},  {31'b0, D_valid}, {31'b0, e.d_valid});
        chk({tag, "_cnt"},   fetch_cnt,        e.cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_err      = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        D_br_taken = 1'b0;
        D_rs_data  = 32'h0;
        load_mem();

        // Sequential fetch
        do_reset();
        step("seq1", 1'b0, 32'h3004, 32'h3000, 1'b1, 1);
        step("seq2", 1'b0, 32'h3008, 32'h3004, 1'b1, 2);
        step("seq3", 1'b0, 32'h300C, 32'h3008, 1'b1, 3);

        // beq taken at 3004, imm 3
        load_mem();
        imem[1] = 32'h1000_0003;
        D_br_taken = 1'b1;
        do_reset();
        step("bt1", 1'b0, 32'h3004, 32'h3000, 1'b1, 1);
        step("bt2", 1'b0, 32'h3008, 32'h3004, 1'b1, 2);
        step("bt3", 1'b0, 32'h3014, 32'h3008, 1'b1, 3);
        step("bt4", 1'b0, 32'h3018, 32'h3014, 1'b1, 4);

        // beq not taken
        D_br_taken = 1'b0;
        do_reset();
        step("bn1", 1'b0, 32'h3004, 32'h3000, 1'b1, 1);
        step("bn2", 1'b0, 32'h3008, 32'h3004, 1'b1, 2);
        step("bn3", 1'b0, 32'h300C, 32'h3008, 1'b1, 3);

        // j at 3000 to 3040
        load_mem();
        imem[0] = 32'h0800_0C10;
        do_reset();
        step("j1", 1'b0, 32'h3004, 32'h3000, 1'b1, 1);
        step("j2", 1'b0, 32'h3040, 32'h3004, 1'b1, 2);
        step("j3", 1'b0, 32'h3044, 32'h3040, 1'b1, 3);

        // jr held in D across a two-cycle stall
        load_mem();
        imem[0] = 32'h03E0_0008;
        D_rs_data = 32'h0000_3100;
        do_reset();
        step("jr1", 1'b0, 32'h3004, 32'h3000, 1'b1, 1);
        step("jrs1", 1'b1, 32'h3004, 32'h3000, 1'b1, 1);
        step("jrs2", 1'b1, 32'h3004, 32'h3000, 1'b1, 1);
        step("jr2", 1'b0, 32'h3100, 32'h3004, 1'b1, 2);
        step("jr3", 1'b0, 32'h3104, 32'h3100, 1'b1, 3);

        // Asynchronous reset between edges while stalled at 3020
        load_mem();
        do_reset();
        for (int i = 1; i <= 8; i++)
            step("run", 1'b0, 32'h3000 + 32'(4 * i), 32'h3000 + 32'(4 * (i - 1)), 1'b1, 32'(i));
        step("hold", 1'b1, 32'h3020, 32'h301C, 1'b1, 8);
        #4;
        reset = 1'b1;
        #1;
        reset_checks("arst");
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;

        // jr below the image base
        load_mem();
        imem[0] = 32'h03E0_0008;
        D_rs_data = 32'h0000_2FFC;
        do_reset();
        step("lo1", 1'b0, 32'h3004, 32'h3000, 1'b1, 1);
        step("lo2", 1'b0, 32'h2FFC, 32'h3004, 1'b1, 2);
`ifdef FETCH_ADDR_CHECK_EN
        chk("lo_exc", {31'b0, F_exc}, 32'h1);
        step("lo3", 1'b0, 32'h3000, 32'h2FFC, 1'b0, 2);
        chk("lo_exc_clr", {31'b0, F_exc}, 32'h0);
`else
        chk("lo_exc", {31'b0, F_exc}, 32'h0);
        step("lo3", 1'b0, 32'h3000, 32'h2FFC, 1'b1, 3);

        // Misaligned jr target is loaded unchanged
        D_rs_data = 32'h0000_3102;
        do_reset();
        step("mis1", 1'b0, 32'h3004, 32'h3000, 1'b1, 1);
        step("mis2", 1'b0, 32'h3102, 32'h3004, 1'b1, 2);
        chk("mis_exc", {31'b0, F_exc}, 32'h0);
        step("mis3", 1'b0, 32'h3106, 32'h3102, 1'b1, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- F-stage front end of the five-stage MIPS pipeline.
- Owns the program counter and drives `F_PC` into the instruction memory, which returns `F_instr` combinationally.
- Computes the next PC from D-stage control: sequential, branch, j/jal and jr, with architectural delay slots.
- Holds the F/D pipeline register (`D_PC`, `D_instr`, `D_valid`), handles hazard stalls, and keeps a fetch counter.

Parameters:
- `PC_RESET`, default 32'h0000_3000: PC value after reset; base of instruction memory.
- `IM_WORDS`, default 4096: instruction memory depth in words; used only by the address check.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: from hazard unit; freezes the PC and the F/D register.
- `D_npc_sel`  in  2: next-PC source from the D-stage decoder. 00 = PC+4, 01 = branch, 10 = j/jal, 11 = jr.
- `D_br_taken`  in  1: D-stage branch comparison result; only meaningful when `D_npc_sel`=01.
- `D_rs_data`  in  32: forwarded rs value, used as the jr target.
- `F_instr`  in  32: instruction word from instruction memory at `F_PC`.
- `F_PC`  out  32: current fetch address.
- `D_PC`  out  32: PC of the instruction held in D.
- `D_instr`  out  32: instruction held in D.
- `D_valid`  out  1: D holds a real fetched instruction (0 = bubble).
- `fetch_cnt`  out  32: number of instructions accepted into D since reset.
- `F_exc`  out  1: fetch address fault; only present with the macro, tied 0 otherwise.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-stall):
  - `F_PC`=`PC_RESET`, `D_PC`=`PC_RESET`, `D_instr`=0 (nop), `D_valid`=0, `fetch_cnt`=0, `F_exc`=0.
- Redirect condition: `redirect` = `D_valid` & (`D_npc_sel`=10 | `D_npc_sel`=11 | (`D_npc_sel`=01 & `D_br_taken`)).
- Next-PC selection (combinational):
  - If redirect:
    - 01: `D_PC`+4+(sign_ext(imm16)<<2), where imm16 = `D_instr`[15:0].
    - 10: {`D_PC`[31:28], `D_instr`[25:0], 2'b00}.
    - 11: `D_rs_data`.
  - Otherwise: `F_PC`+4.
  - All arithmetic is modulo 2^32; wrap at 32'hFFFF_FFFC to 0 is silent.
- Delay slot:
  - The word being fetched while a jump or branch sits in D is the delay slot.
  - It is always accepted into D and is never squashed.
  - The target is fetched on the following cycle.
- Normal cycle (`stall`=0), at the rising edge:
  - `F_PC`<=NPC.
  - `D_PC`<=`F_PC`, `D_instr`<=`F_instr`, `D_valid`<=1.
  - `fetch_cnt`<=`fetch_cnt`+1, wrapping at 2^32.
- Stall cycle (`stall`=1):
  - `F_PC`, `D_PC`, `D_instr`, `D_valid` and `fetch_cnt` all hold.
  - Redirect is evaluated but not applied. Because the held D instruction re-evaluates it on the first unstalled cycle, no target is lost.
- Bubble in D (`D_valid`=0): `D_npc_sel` and `D_br_taken` are ignored, and NPC = `F_PC`+4.
- Latency: one cycle from `F_PC` presentation to the instruction appearing in D. A redirect target appears on `F_PC` one cycle after the branch is in D with `stall`=0.
- Misaligned jr target (`D_rs_data`[1:0]≠0):
  - Loaded into `F_PC` unchanged.
  - The memory index ignores bits [1:0].
  - Flagged only under the optional feature.

Optional Feature:
- Macro: `FETCH_ADDR_CHECK_EN`.
- Defined:
  - `F_exc`=1 combinationally when `F_PC`[1:0]≠0 or `F_PC` lies outside [`PC_RESET`, `PC_RESET`+4*`IM_WORDS`).
  - On a normal cycle with `F_exc`=1, D captures `D_instr`=0 (nop) and `D_valid`=0 instead of `F_instr`.
  - `fetch_cnt` does not increment on that cycle.
  - The PC still advances per NPC.
- Undefined:
  - `F_exc` is tied 0.
  - `F_instr` is always captured, whatever the address.

Test Plan:
- Reset release, `stall`=0, sequential code for 3 cycles:
  - `F_PC` goes 3000 -> 3004 -> 3008 -> 300C.
  - `D_PC` lags `F_PC` by one cycle.
  - `D_valid` becomes 1 after the first edge; `fetch_cnt`=3.
- beq at 3004 with imm16=16'h0003, `D_br_taken`=1:
  - Delay slot 3008 enters D.
  - Next `F_PC`=3014 (3008+12).
  - With `D_br_taken`=0, `F_PC`=300C instead.
- j at 3000 with imm26=26'h0000C10:
  - After the delay slot fetch, `F_PC`=3040.
- jr with `D_rs_data`=32'h0000_3100 while `stall`=1 for 2 cycles:
  - `F_PC`, D registers and `fetch_cnt` hold throughout the stall.
  - On the first unstalled edge, `F_PC`=3100.
- Assert `reset` asynchronously mid-stall, between clock edges, with `F_PC`=3020:
  - All outputs return to their reset values immediately, before the next edge.
- With `FETCH_ADDR_CHECK_EN`, jr to 32'h0000_2FFC:
  - `F_exc`=1.
  - Next D is a nop bubble with `D_valid`=0; `fetch_cnt` unchanged.
